// File: rtl/sync_down_counter8_pkg.sv
// Shared width and reset constants for the 8-bit down counter.
// Integrators take the count width from here.
package sync_down_counter8_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_RESET = 8'h00;

endpackage

// File: rtl/sync_down_counter8.sv
// Free-running down counter with clock enable; wraps 0x00 -> 0xFF.
// terminal_count flags the all-zero count for wrap detection downstream.
module sync_down_counter8
  import sync_down_counter8_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = COUNT_RESET
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count_out,
  output logic             terminal_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  // Borrow out of the subtraction is dropped, giving the modulo-2^WIDTH wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VALUE;
    end else if (enable) begin
      count_q <= count_q - ONE;
    end
  end

  assign count_out      = count_q;
  assign terminal_count = ~|count_q;

endmodule

// File: tb/tb_sync_down_counter8.sv
// Directed bench for sync_down_counter8: reset, counting, hold, full wrap,
// asynchronous mid-count reset and enable held during reset.
module tb_sync_down_counter8;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] count_out;
  logic       terminal_count;

  int n_checks = 0;
  int n_fail   = 0;

  sync_down_counter8 dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .count_out      (count_out),
    .terminal_count (terminal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] exp_cnt;
  int         tc_pulses;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;

    // Power-up reset, checked before the next rising edge at t=15.
    #5;
    reset = 1'b0;
    #1;
    check_val("reset_count", {24'b0, count_out}, 32'h00);
    check_val("reset_tc", {31'b0, terminal_count}, 32'h1);
    #9;
    reset = 1'b1;

    // 20 enabled edges: 0xFF down to 0xEC.
    @(negedge clock);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check_val("count_seq", {24'b0, count_out}, 32'hFF - i);
      check_val("count_seq_tc", {31'b0, terminal_count}, 32'h0);
    end

    // Hold for 5 edges.
    @(negedge clock);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check_val("hold", {24'b0, count_out}, 32'hEC);
    end

    // Run down from 0xEC to 0x00 (236 edges).
    @(negedge clock);
    enable = 1'b1;
    repeat (236) @(posedge clock);
    #1;
    check_val("reach_zero", {24'b0, count_out}, 32'h00);
    check_val("reach_zero_tc", {31'b0, terminal_count}, 32'h1);

    // Full wrap: 256 edges from 0x00 back to 0x00.
    exp_cnt   = 8'h00;
    tc_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clock);
      #1;
      exp_cnt = exp_cnt - 8'd1;
      if (i == 0) check_val("wrap_first", {24'b0, count_out}, 32'hFF);
      check_val("wrap_count", {24'b0, count_out}, {24'b0, exp_cnt});
      check_val("wrap_tc", {31'b0, terminal_count}, {31'b0, (exp_cnt == 8'h00)});
      if (terminal_count === 1'b1) tc_pulses++;
    end
    check_val("wrap_end", {24'b0, count_out}, 32'h00);
    check_val("wrap_tc_pulses", tc_pulses, 32'd1);

    // 128 edges from 0x00 reach 0x80.
    repeat (128) @(posedge clock);
    #1;
    check_val("mid_value", {24'b0, count_out}, 32'h80);

    // Asynchronous reset between edges, enable still high.
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("async_reset", {24'b0, count_out}, 32'h00);
    check_val("async_reset_tc", {31'b0, terminal_count}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_val("enable_in_reset", {24'b0, count_out}, 32'h00);
    end

    // First enabled edge after release gives 0xFF.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_val("post_release", {24'b0, count_out}, 32'hFF);
    check_val("post_release_tc", {31'b0, terminal_count}, 32'h0);

    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check_val("final_hold", {24'b0, count_out}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
